// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice reused across WIDTH clocks, one sum bit per edge.
// Defining SERIAL_ADD_CTRL_SUB_EN adds a `sub` port that selects two's-complement a-b.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Full-adder slice: two half adders, carries merged with an OR.
  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic s_d, carry_d;
  assign ha0_s   = sa_q[0] ^ sb_q[0];
  assign ha0_c   = sa_q[0] & sb_q[0];
  assign ha1_s   = ha0_s ^ carry_q;
  assign ha1_c   = ha0_s & carry_q;
  assign s_d     = ha1_s;
  assign carry_d = ha0_c | ha1_c;

  logic [WIDTH-1:0] sb_load_d;
  logic             carry_load_d;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  // Subtract as a + ~b + 1: invert B and seed the carry.
  assign sb_load_d    = sub ? ~b : b;
  assign carry_load_d = sub;
`else
  assign sb_load_d    = b;
  assign carry_load_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= sb_load_d;
            carry_q <= carry_load_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q   <= {s_d, sum_q[WIDTH-1:1]};
          sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
          carry_q <= carry_d;
          if (cnt_q == CNT_LAST) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized bench for serial_add_ctrl at WIDTH=8.
// Define SERIAL_ADD_CTRL_SUB_EN to also exercise subtract mode.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub_s;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int vectors = 0;
  int miscompares = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub  (sub_s),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain (W+1)-bit arithmetic; bit W is the carry out.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, cout, exp_cout);
  endtask

  // Called #1 after an edge with the DUT in IDLE or DONE; returns #1 after the done edge.
  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss,
                    input bit chain, input int pulse_at);
    logic [W:0] e;
    start = 1'b1; a = aa; b = bb; sub_s = ss;
    @(posedge clk); #1;
    exp_q.push_back(model(aa, bb, ss));
    start = chain; a = W'($urandom); b = W'($urandom); sub_s = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      if (k == pulse_at) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else if (k == pulse_at + 1) begin
        start = chain;
      end
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_sum", sum, e[W-1:0]);
    chk("end_cout", cout, e[W]);
    exp_sum = e[W-1:0];
    exp_cout = e[W];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_idle_outputs("idle");
    end
  endtask

  initial begin
    // Clock/reset
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub_s = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_outputs("post_reset");

    // Directed cases
    op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    idle(2);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    idle(20);
    op(8'h10, 8'h20, 1'b0, 1'b0, 3);
    idle(3);
    op(8'hFF, 8'hFF, 1'b0, 1'b0, 0);

    // Abort mid-run: reset raised just before E4
    start = 1'b1; a = 8'h0F; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp_sum = '0; exp_cout = 1'b0;
    chk_idle_outputs("abort");
    @(posedge clk); #1;
    chk_idle_outputs("abort_hold");
    rst = 1'b0;
    idle(W + 3);
    op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    idle(1);

    // Back-to-back with start held high
    op(8'h01, 8'h02, 1'b0, 1'b1, 0);
    op(8'h80, 8'h80, 1'b0, 1'b0, 0);
    idle(2);

`ifdef SERIAL_ADD_CTRL_SUB_EN
    op(8'h10, 8'h01, 1'b1, 1'b0, 0);
    idle(1);
    op(8'h01, 8'h02, 1'b1, 1'b0, 0);
    idle(1);
    op(8'h01, 8'h02, 1'b0, 1'b0, 0);
    idle(1);
`endif

    // Randomized operations, random back-to-back chaining
    for (int n = 0; n < 30; n++) begin
      logic ss;
      bit   ch;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      ss = 1'($urandom_range(0, 1));
`else
      ss = 1'b0;
`endif
      ch = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      op(W'($urandom), W'($urandom), ss, ch, 0);
      if (!ch) idle($urandom_range(0, 3));
    end
    idle(2);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
